// File: rtl/wd279x_pkg.sv
// Shared constants, ID-field byte indices and FSM state encoding for the WD279x ID reader.
package wd279x_pkg;

  localparam int ID_TRACK  = 0;
  localparam int ID_SIDE   = 1;
  localparam int ID_SECTOR = 2;
  localparam int ID_LENGTH = 3;
  localparam int ID_CRC1   = 4;
  localparam int ID_CRC2   = 5;
  localparam int ID_BYTES  = 6;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  localparam logic [7:0] MARK_A1 = 8'hA1;
  localparam logic [7:0] MARK_FE = 8'hFE;

  // Number of A1 sync marks that must precede the FE address mark in MFM
  localparam logic [1:0] SYNC_MARKS = 2'd3;

  typedef enum logic [2:0] {
    HUNT,
    SYNC,
    AM,
    FIELD,
    CHECK
  } state_t;

endpackage

// File: rtl/wd279x_crc16.sv
// Combinational byte-wide CRC-16-CCITT step (poly 1021, MSB first): one data byte per call.
module wd279x_crc16
  import wd279x_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  byte_in,
  output logic [15:0] crc_out
);

  logic [15:0] stage [9];

  assign stage[0] = crc_in;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bit
      logic fb;
      assign fb           = stage[gi][15] ^ byte_in[7-gi];
      assign stage[gi+1]  = {stage[gi][14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    end
  endgenerate

  assign crc_out = stage[8];

endmodule

// File: rtl/wd279x_id_reader.sv
// WD279x-style ID address-field reader: hunts for sync/address marks, captures the six ID bytes
// and checks the CRC. Define WD279X_FM_EN to also accept single-density (FM) FE marks when dden_n=1.
module wd279x_id_reader
  import wd279x_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      dden_n,
  input  logic [7:0]                data_in,
  input  logic                      data_stb,
  input  logic                      mark_in,
  output logic [ID_BYTES-1:0][7:0]  sec_id,
  output logic                      data_valid,
  output logic                      crc_error,
  output logic                      busy
);

  state_t                     state_reg, state_next;
  logic [15:0]                crc_reg, crc_next;
  logic [1:0]                 sync_cnt_reg, sync_cnt_next;
  logic [2:0]                 byte_idx_reg, byte_idx_next;
  logic [ID_BYTES-1:0][7:0]   shadow_reg;
  logic [ID_BYTES-1:0][7:0]   sec_id_reg;

  logic [15:0] crc_run;
  logic [15:0] crc_seed;
  logic [1:0]  sync_cnt_inc;
  logic        fm_mode;
  logic        hunt_a1;
  logic        hunt_fe;
  logic        hunt_take;
  logic        field_wr;
  logic        check_live;

`ifdef WD279X_FM_EN
  assign fm_mode = dden_n;
`else
  logic dden_unused;
  assign fm_mode     = 1'b0;
  assign dden_unused = dden_n;
`endif

  // Running CRC for bytes inside a field, and a freshly preset CRC for a mark seen while hunting
  wd279x_crc16 u_crc_run (
    .crc_in  (crc_reg),
    .byte_in (data_in),
    .crc_out (crc_run)
  );

  wd279x_crc16 u_crc_seed (
    .crc_in  (CRC_INIT),
    .byte_in (data_in),
    .crc_out (crc_seed)
  );

  assign sync_cnt_inc = sync_cnt_reg + 2'd1;
  assign hunt_a1      = mark_in && !fm_mode && (data_in == MARK_A1);
  assign hunt_fe      = mark_in &&  fm_mode && (data_in == MARK_FE);
  assign field_wr     = enable && data_stb && !mark_in && (state_reg == FIELD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= HUNT;
      crc_reg      <= CRC_INIT;
      sync_cnt_reg <= '0;
      byte_idx_reg <= '0;
      shadow_reg   <= '0;
      sec_id_reg   <= '0;
    end else begin
      if (data_valid)
        sec_id_reg <= shadow_reg;
      if (field_wr) begin
        for (int i = 0; i < ID_BYTES; i++)
          if (byte_idx_reg == 3'(i))
            shadow_reg[i] <= data_in;
      end
      if (!enable) begin
        state_reg <= HUNT;
      end else begin
        state_reg    <= state_next;
        crc_reg      <= crc_next;
        sync_cnt_reg <= sync_cnt_next;
        byte_idx_reg <= byte_idx_next;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    crc_next      = crc_reg;
    sync_cnt_next = sync_cnt_reg;
    byte_idx_next = byte_idx_reg;
    hunt_take     = 1'b0;

    case (state_reg)
      HUNT: begin
        if (data_stb)
          hunt_take = 1'b1;
      end
      SYNC: begin
        if (data_stb) begin
          if (mark_in && data_in == MARK_A1) begin
            crc_next      = crc_run;
            sync_cnt_next = sync_cnt_inc;
            if (sync_cnt_inc == SYNC_MARKS)
              state_next = AM;
          end else begin
            state_next = HUNT;
          end
        end
      end
      AM: begin
        if (data_stb) begin
          if (!mark_in && data_in == MARK_FE) begin
            state_next    = FIELD;
            crc_next      = crc_run;
            byte_idx_next = '0;
          end else if (!(mark_in && data_in == MARK_A1)) begin
            state_next = HUNT;
          end
          // An extra A1 keeps the CRC as it was on entry to AM, i.e. the CRC over three A1s
        end
      end
      FIELD: begin
        if (data_stb) begin
          if (mark_in) begin
            hunt_take = 1'b1;
          end else begin
            crc_next      = crc_run;
            byte_idx_next = byte_idx_reg + 3'd1;
            if (byte_idx_reg == 3'(ID_CRC2))
              state_next = CHECK;
          end
        end
      end
      CHECK: begin
        state_next = HUNT;
        if (data_stb)
          hunt_take = 1'b1;
      end
      default: state_next = HUNT;
    endcase

    // Bytes seen while hunting, a mark that breaks a field, or a byte arriving during CHECK
    if (hunt_take) begin
      sync_cnt_next = '0;
      byte_idx_next = '0;
      state_next    = HUNT;
      if (hunt_a1) begin
        state_next    = SYNC;
        crc_next      = crc_seed;
        sync_cnt_next = 2'd1;
      end else if (hunt_fe) begin
        state_next = FIELD;
        crc_next   = crc_seed;
      end
    end
  end

  always_comb begin
    busy       = (state_reg != HUNT);
    check_live = (state_reg == CHECK) && enable && !reset;
    data_valid = check_live && (crc_reg == 16'h0000);
    crc_error  = check_live && (crc_reg != 16'h0000);
    sec_id     = data_valid ? shadow_reg : sec_id_reg;
  end

endmodule

// File: tb/tb_wd279x_id_reader.sv
// Self-checking bench for wd279x_id_reader: randomized ID fields against a scoreboard of expected pulses.
module tb_wd279x_id_reader;
  import wd279x_pkg::*;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     enable;
  logic                     dden_n;
  logic [7:0]               data_in;
  logic                     data_stb;
  logic                     mark_in;
  logic [ID_BYTES-1:0][7:0] sec_id;
  logic                     data_valid;
  logic                     crc_error;
  logic                     busy;

  always #5 clk = ~clk;

  wd279x_id_reader dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .dden_n     (dden_n),
    .data_in    (data_in),
    .data_stb   (data_stb),
    .mark_in    (mark_in),
    .sec_id     (sec_id),
    .data_valid (data_valid),
    .crc_error  (crc_error),
    .busy       (busy)
  );

  typedef struct {
    bit          good;
    logic [47:0] sid;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  logic [47:0] last_good;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference CRC-CCITT: xor byte into the high half, then eight polynomial divisions
  function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int k = 0; k < 8; k++)
      r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every pulse must match the oldest expected outcome
  always @(negedge clk) begin
    if (data_valid || crc_error) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: data_valid=%b crc_error=%b sec_id=%h, expected no pulse",
                 data_valid, crc_error, sec_id);
      end else begin
        e = sb.pop_front();
        check("data_valid", data_valid, e.good);
        check("crc_error", crc_error, !e.good);
        check("sec_id", sec_id, e.sid);
        check("latency", cyc, e.cyc);
        $display("[TB] cyc %0d: data_valid=%b crc_error=%b sec_id=%h", cyc, data_valid, crc_error, sec_id);
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit m);
    data_in  = b;
    mark_in  = m;
    data_stb = 1'b1;
    @(posedge clk); #1;
    data_stb = 1'b0;
    mark_in  = 1'b0;
    data_in  = 8'($urandom);
    repeat ($urandom_range(0, 1)) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_id(input logic [7:0] t, input logic [7:0] s, input logic [7:0] n,
                         input logic [7:0] l, input bit corrupt, input int a1s);
    logic [15:0] c;
    logic [7:0]  c2;
    logic [47:0] sid;
    exp_t        x;
    c = CRC_INIT;
    repeat (3) c = ref_crc(c, 8'hA1);
    c = ref_crc(c, 8'hFE);
    c = ref_crc(c, t);
    c = ref_crc(c, s);
    c = ref_crc(c, n);
    c = ref_crc(c, l);
    c2 = c[7:0];
    if (corrupt) c2 = c2 ^ 8'($urandom_range(1, 255));
    repeat (a1s) send(8'hA1, 1'b1);
    send(8'hFE, 1'b0);
    send(t, 1'b0);
    send(s, 1'b0);
    send(n, 1'b0);
    send(l, 1'b0);
    send(c[15:8], 1'b0);
    sid = {c2, c[15:8], l, n, s, t};
    x.good = !corrupt;
    x.sid  = corrupt ? last_good : sid;
    x.cyc  = cyc + 1;
    if (!corrupt) last_good = sid;
    sb.push_back(x);
    send(c2, 1'b0);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    check({name, "_drained"}, sb.size(), 0);
    check({name, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    enable    = 1'b1;
    dden_n    = 1'b0;
    data_stb  = 1'b0;
    mark_in   = 1'b0;
    data_in   = 8'h00;
    last_good = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_busy", busy, 1'b0);
    check("reset_sec_id", sec_id, 48'h0);
    check("reset_data_valid", data_valid, 1'b0);
    check("reset_crc_error", crc_error, 1'b0);

    // Good field, then the same field with a corrupted second CRC byte
    send_id(8'h05, 8'h00, 8'h03, 8'h02, 1'b0, 3);
    drain("good_field");
    send_id(8'h05, 8'h00, 8'h03, 8'h02, 1'b1, 3);
    drain("bad_crc");

    // Two A1s then an ordinary byte: back to hunting, trailing bytes ignored
    send(8'hA1, 1'b1);
    send(8'hA1, 1'b1);
    send(8'h4E, 1'b0);
    send(8'hFE, 1'b0);
    repeat (6) send(8'($urandom), 1'b0);
    send_id(8'h11, 8'h01, 8'h09, 8'h01, 1'b0, 3);
    drain("short_sync");

    // Reset part way through a field
    repeat (3) send(8'hA1, 1'b1);
    send(8'hFE, 1'b0);
    repeat (4) send(8'($urandom), 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    last_good = '0;
    check("midfield_reset_sec_id", sec_id, 48'h0);
    check("midfield_reset_busy", busy, 1'b0);
    send(8'($urandom), 1'b0);
    send(8'($urandom), 1'b0);
    drain("after_reset");

    // A1 mark at field index 2 restarts sync; two more A1s complete it
    repeat (3) send(8'hA1, 1'b1);
    send(8'hFE, 1'b0);
    send(8'h22, 1'b0);
    send(8'h00, 1'b0);
    send(8'hA1, 1'b1);
    send_id(8'h23, 8'h01, 8'h07, 8'h03, 1'b0, 2);
    drain("field_abort");

    // Enable dropped mid-field
    repeat (3) send(8'hA1, 1'b1);
    send(8'hFE, 1'b0);
    repeat (3) send(8'($urandom), 1'b0);
    enable = 1'b0;
    @(posedge clk); #1;
    check("enable_abort_busy", busy, 1'b0);
    enable = 1'b1;
    repeat (3) send(8'($urandom), 1'b0);
    send_id(8'h30, 8'h00, 8'h01, 8'h02, 1'b0, 3);
    drain("enable_abort");

    // Randomized traffic: junk, false syncs, extra A1s, occasional CRC faults
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 3)) send(8'($urandom), 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        send(8'hA1, 1'b1);
        send(8'($urandom_range(0, 8'hA0)), 1'b0);
      end
      send_id(8'($urandom), 8'($urandom_range(0, 1)), 8'($urandom), 8'($urandom_range(0, 3)),
              ($urandom_range(0, 3) == 0), 3 + $urandom_range(0, 2));
    end
    drain("random");

`ifdef WD279X_FM_EN
    begin
      logic [15:0] c;
      exp_t        x;
      dden_n = 1'b1;
      c = ref_crc(CRC_INIT, 8'hFE);
      c = ref_crc(c, 8'h0A);
      repeat (3) c = ref_crc(c, 8'h01);
      send(8'hFE, 1'b1);
      send(8'h0A, 1'b0);
      repeat (3) send(8'h01, 1'b0);
      send(c[15:8], 1'b0);
      x.good = 1'b1;
      x.sid  = {c[7:0], c[15:8], 8'h01, 8'h01, 8'h01, 8'h0A};
      x.cyc  = cyc + 1;
      last_good = x.sid;
      sb.push_back(x);
      send(c[7:0], 1'b0);
      drain("fm_field");
      check("fm_track", sec_id[ID_TRACK], 8'h0A);
      dden_n = 1'b0;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
